// File: rtl/aud_pkg.sv
// aud_pkg: types and sizes shared by the audio record/playback path.
//   DATA_W    sample width (bits per I2S channel slot)
//   ADDR_W    SRAM word address width
//   BITCNT_W  width of a counter that holds 0..DATA_W
//   play_state_e  playback FSM states
//   chan_e        I2S slot currently being serialized
package aud_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 20;
  localparam int BITCNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_SEND  = 2'd2,
    S_PAUSE = 2'd3
  } play_state_e;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_e;

endpackage

// File: rtl/aud_i2s_serializer.sv
// aud_i2s_serializer: I2S transmit slice for one mono sample per frame.
// Detects DACLRCK edges, shifts the sample MSB-first into the left slot, replays
// the same sample into the right slot, and pads with 0 once DATA_W bits are out.
//   i_clk/i_rst_n  BCLK, async active-low reset
//   i_lrc          DACLRCK (0 = left, 1 = right)
//   i_clr          abort: drop the current slot and drive 0
//   i_load         start a frame with i_sample (asserted on the LRC fall)
//   i_run          serializer active (playback FSM in its send state)
//   i_sample       SRAM word for the frame being started
//   o_fall         LRC falling edge seen this cycle (frame start)
//   o_frame_end    right slot has shifted out all of its bits (one cycle)
//   o_dac          DACDAT
module aud_i2s_serializer
  import aud_pkg::*;
#(
  parameter int DATA_W = aud_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_run,
  input  logic [DATA_W-1:0] i_sample,
  output logic              o_fall,
  output logic              o_frame_end,
  output logic              o_dac
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);

  logic              r_lrc_q;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_sample;
  logic [CW-1:0]     r_bit_cnt;
  chan_e             r_chan;
  logic              r_dac;
  logic              w_rise;

  assign o_fall   = r_lrc_q & ~i_lrc;
  assign w_rise   = ~r_lrc_q & i_lrc;
  assign o_dac    = r_dac;
  // A fall has priority (new frame / short slot), so frame end is only
  // reported when no frame is starting on the same edge.
  assign o_frame_end = i_run & ~o_fall & (r_chan == CH_R) & (r_bit_cnt == FULL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lrc_q <= 1'b0;
    else          r_lrc_q <= i_lrc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg   <= '0;
      r_sample  <= '0;
      r_bit_cnt <= '0;
      r_chan    <= CH_L;
      r_dac     <= 1'b0;
    end else if (i_clr) begin
      r_bit_cnt <= '0;
      r_chan    <= CH_L;
      r_dac     <= 1'b0;
    end else if (i_load) begin
      // MSB goes out on the edge that saw LRC change; the codec takes it one
      // BCLK later, which is the I2S one-bit delay.
      r_sample  <= i_sample;
      r_shreg   <= {i_sample[DATA_W-2:0], 1'b0};
      r_dac     <= i_sample[DATA_W-1];
      r_bit_cnt <= CW'(1);
      r_chan    <= CH_L;
    end else if (i_run) begin
      if (w_rise && r_chan == CH_L) begin
        r_shreg   <= {r_sample[DATA_W-2:0], 1'b0};
        r_dac     <= r_sample[DATA_W-1];
        r_bit_cnt <= CW'(1);
        r_chan    <= CH_R;
      end else if (r_bit_cnt < FULL) begin
        r_dac     <= r_shreg[DATA_W-1];
        r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end else begin
        r_dac <= 1'b0;
        // Flip back to left once the right slot is finished so frame end
        // fires exactly once while padding to the next fall.
        if (r_chan == CH_R) r_chan <= CH_L;
      end
    end else begin
      r_dac <= 1'b0;
    end
  end

endmodule

// File: rtl/aud_sram_player.sv
// aud_sram_player: plays SRAM words 0..i_end_addr as mono I2S on DACDAT.
// The codec is clock master (i_clk = BCLK, i_lrc = DACLRCK). Each word is sent
// MSB-first in the left slot and again in the right slot.
//   i_start     pulse: start from address 0 (idle) or resume (paused)
//   i_pause     pulse: stop at the end of the current frame, keep address
//   i_stop      abort now, rewind to 0, no done
//   i_end_addr  last address played (inclusive), latched on start from idle
//   i_sram_data combinational read data for o_address
//   o_address   SRAM read address
//   o_dac_data  DACDAT
//   o_playing   1 while waiting for a frame start or sending
//   o_done      one-cycle pulse after the last word's right slot
module aud_sram_player
  import aud_pkg::*;
#(
  parameter int DATA_W = aud_pkg::DATA_W,
  parameter int ADDR_W = aud_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_dac_data,
  output logic              o_playing,
  output logic              o_done
);

  play_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] r_end;
  logic              r_pause_pend;
  logic              r_done;

  logic w_fall, w_frame_end, w_load, w_run, w_active;
  logic w_addr_clr, w_addr_inc, w_latch_end, w_done_set, w_pend_clr, w_pend_set;

  assign w_active = (r_state == S_SYNC) | (r_state == S_SEND);
  assign w_load   = ~i_stop & w_active & w_fall;
  assign w_run    = ~i_stop & (r_state == S_SEND);

  aud_i2s_serializer #(.DATA_W(DATA_W)) u_ser (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_lrc       (i_lrc),
    .i_clr       (i_stop),
    .i_load      (w_load),
    .i_run       (w_run),
    .i_sample    (i_sram_data),
    .o_fall      (w_fall),
    .o_frame_end (w_frame_end),
    .o_dac       (o_dac_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_clr  = 1'b0;
    w_addr_inc  = 1'b0;
    w_latch_end = 1'b0;
    w_done_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_pend_set  = 1'b0;
    if (i_stop) begin
      w_state_nxt = S_IDLE;
      w_addr_clr  = 1'b1;
      w_pend_clr  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_latch_end = 1'b1;
            w_addr_clr  = 1'b1;
            w_state_nxt = S_SYNC;
          end
        end
        S_SYNC: begin
          w_pend_set = i_pause;
          if (w_fall) w_state_nxt = S_SEND;
        end
        S_SEND: begin
          w_pend_set = i_pause;
          if (w_frame_end) begin
            if (r_address == r_end) begin
              w_done_set  = 1'b1;
              w_addr_clr  = 1'b1;
              w_pend_clr  = 1'b1;
              w_state_nxt = S_IDLE;
            end else if (r_pause_pend || i_pause) begin
              w_addr_inc  = 1'b1;
              w_pend_clr  = 1'b1;
              w_state_nxt = S_PAUSE;
            end else begin
              // Next word is read well before the next LRC fall.
              w_addr_inc = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (i_start) w_state_nxt = S_SYNC;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_address    <= '0;
      r_end        <= '0;
      r_pause_pend <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_latch_end) r_end <= i_end_addr;
      if (w_addr_clr)      r_address <= '0;
      else if (w_addr_inc) r_address <= r_address + ADDR_W'(1);
      if (w_pend_clr)      r_pause_pend <= 1'b0;
      else if (w_pend_set) r_pause_pend <= 1'b1;
    end
  end

  assign o_address = r_address;
  assign o_playing = w_active;
  assign o_done    = r_done;

endmodule

// File: tb/tb_aud_sram_player.sv
// tb_aud_sram_player: codec model (LRC toggles every 20 BCLK, DACDAT captured
// per slot) plus directed and randomized playback runs. Expected slot streams
// come from the SRAM contents: each played word appears as a left then a right
// slot, MSB first, followed by zero padding.
module tb_aud_sram_player;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n, lrc, start, pause, stop;
  logic [AW-1:0] end_addr;
  logic [15:0]   sram_data;
  logic [AW-1:0] address;
  logic          dac, playing, done;
  logic [15:0]   mem [0:63];

  assign sram_data = mem[address[5:0]];

  aud_sram_player dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_lrc       (lrc),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_end_addr  (end_addr),
    .i_sram_data (sram_data),
    .o_address   (address),
    .o_dac_data  (dac),
    .o_playing   (playing),
    .o_done      (done)
  );

  initial forever #5 clk = ~clk;

  // ---- codec model ------------------------------------------------------
  typedef struct packed { logic ch; logic [19:0] bits; } slot_t;
  slot_t       cap_q[$];
  int          cod_cnt;
  int          done_cnt;
  logic [19:0] sh;

  initial begin
    slot_t s;
    lrc = 1'b0; cod_cnt = 0; done_cnt = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      cod_cnt++;
      sh = {sh[18:0], dac};
      if (cod_cnt == 20) begin
        if (sh != '0) begin
          s.ch = lrc; s.bits = sh;
          cap_q.push_back(s);
        end
        lrc = ~lrc; cod_cnt = 0; sh = '0;
      end
    end
  end

  // ---- checking helpers -------------------------------------------------
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_frames(input string name, input int base, input int first, input int last);
    slot_t exp_q[$];
    slot_t s;
    for (int a = first; a <= last; a++) begin
      s.bits = {mem[a], 4'h0};
      s.ch = 1'b0; exp_q.push_back(s);
      s.ch = 1'b1; exp_q.push_back(s);
    end
    check({name, "_nslots"}, cap_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < cap_q.size(); i++)
      check($sformatf("%s_slot%0d", name, i), cap_q[base + i], exp_q[i]);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_addr(input string name, input logic [AW-1:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (address == a) begin ok = 1'b1; break; end
      step(1);
    end
    check({name, "_reach_addr"}, ok, 1'b1);
  endtask

  task automatic sync_phase(input string name, input logic ch, input int cnt);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (lrc == ch && cod_cnt == cnt) begin ok = 1'b1; break; end
      step(1);
    end
    check({name, "_phase"}, ok, 1'b1);
  endtask

  task automatic pulse_start(input logic [AW-1:0] e);
    end_addr = e; start = 1'b1;
    step(1);
    start = 1'b0; end_addr = '1;  // must have been latched already
  endtask

  task automatic run_play(input string name, input logic [AW-1:0] e, input int dly,
                          input int exp_n, input int exp_done);
    int base, d0;
    bit ok;
    step(dly);
    base = cap_q.size(); d0 = done_cnt;
    pulse_start(e);
    wait_done(exp_n * 40 + 100, ok);
    check({name, "_done_seen"}, ok, 1'b1);
    check({name, "_addr_rewound"}, address, '0);
    check({name, "_idle"}, playing, 1'b0);
    step(1);
    check({name, "_done_one_cycle"}, done, 1'b0);
    step(6);
    check_frames(name, base, 0, exp_n - 1);
    check({name, "_done_count"}, done_cnt - d0, exp_done);
  endtask

  typedef struct {
    logic [AW-1:0] end_addr;
    int            dly;
    int            exp_n;
    int            exp_done;
  } vec_t;

  // ---- test sequence ----------------------------------------------------
  initial begin
    vec_t vecs[4];
    int   base, d0, nz, moved;
    bit   ok;

    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; end_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    mem[0] = 16'h9249; mem[1] = 16'h8001; mem[2] = 16'h7FFE;
    mem[3] = 16'h1234; mem[4] = 16'hC3C3; mem[5] = 16'h0F0F;

    step(3);
    check("rst_addr", address, '0);
    check("rst_dac", dac, 1'b0);
    check("rst_playing", playing, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    step(2);

    // Directed table: three-word run, then varied lengths and start phases.
    vecs[0] = '{end_addr: 20'd2, dly: 0,  exp_n: 3, exp_done: 1};
    vecs[1] = '{end_addr: 20'd1, dly: 13, exp_n: 2, exp_done: 1};
    vecs[2] = '{end_addr: 20'd0, dly: 5,  exp_n: 1, exp_done: 1};
    vecs[3] = '{end_addr: 20'd5, dly: 27, exp_n: 6, exp_done: 1};
    for (int v = 0; v < 4; v++)
      run_play($sformatf("vec%0d", v), vecs[v].end_addr, vecs[v].dly, vecs[v].exp_n, vecs[v].exp_done);

    // Start in the middle of a right slot: silent until the next fall.
    sync_phase("midr", 1'b1, 8);
    run_play("midr", 20'd0, 0, 1, 1);

    // Pause during frame 1: frame 1 completes, address 2 held, silent.
    base = cap_q.size(); d0 = done_cnt;
    pulse_start(20'd5);
    wait_addr("pause", 20'd1);
    sync_phase("pause", 1'b0, 5);
    pause = 1'b1; step(1); pause = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!playing) begin ok = 1'b1; break; end
      step(1);
    end
    check("pause_entered", ok, 1'b1);
    check("pause_addr", address, 20'd2);
    nz = 0; moved = 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (dac !== 1'b0) nz++;
      if (address != 20'd2) moved++;
    end
    check("pause_dac_quiet", nz, 0);
    check("pause_addr_held", moved, 0);
    check("pause_slots", cap_q.size() - base, 4);
    pulse_start(20'd0);  // resume keeps the end latched at start
    wait_done(500, ok);
    check("resume_done_seen", ok, 1'b1);
    step(7);
    check_frames("resume", base, 0, 5);
    check("resume_done_count", done_cnt - d0, 1);

    // Stop during bit 7 of a left slot.
    d0 = done_cnt;
    pulse_start(20'd3);
    wait_addr("stop", 20'd1);
    sync_phase("stop", 1'b0, 7);
    check("stop_playing_before", playing, 1'b1);
    stop = 1'b1; step(1);
    check("stop_dac", dac, 1'b0);
    check("stop_addr", address, '0);
    check("stop_playing", playing, 1'b0);
    check("stop_done", done, 1'b0);
    stop = 1'b0;
    step(50);
    check("stop_no_done", done_cnt - d0, 0);
    run_play("after_stop", 20'd2, 0, 3, 1);

    // Single-word clip, then start and stop together.
    mem[0] = 16'hA5A5;
    run_play("one_word", 20'd0, 3, 1, 1);
    base = cap_q.size(); d0 = done_cnt;
    end_addr = 20'd3; start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    step(2);
    check("startstop_playing", playing, 1'b0);
    step(80);
    check("startstop_slots", cap_q.size() - base, 0);
    check("startstop_done", done_cnt - d0, 0);
    check("startstop_addr", address, '0);

    // Async reset mid right slot.
    mem[0] = 16'h9249;
    d0 = done_cnt;
    pulse_start(20'd3);
    wait_addr("rst", 20'd1);
    sync_phase("rst", 1'b1, 8);
    rst_n = 1'b0; #1;
    check("rst_mid_addr", address, '0);
    check("rst_mid_dac", dac, 1'b0);
    check("rst_mid_playing", playing, 1'b0);
    check("rst_mid_done", done, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(30);
    base = cap_q.size();
    step(100);
    check("rst_after_idle", playing, 1'b0);
    check("rst_after_slots", cap_q.size() - base, 0);
    check("rst_after_done", done_cnt - d0, 0);

    // Randomized runs against the SRAM-derived slot stream.
    for (int r = 0; r < 6; r++) begin
      logic [AW-1:0] e;
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom_range(1, 65535));
      e = AW'($urandom_range(0, 4));
      run_play($sformatf("rnd%0d", r), e, $urandom_range(0, 39), int'(e) + 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
